univ_shift_reg: RTL and testbench

Parametrised universal shift register that generalises the 4-bit buffer/shift register. It supports hold, parallel load, logical shift left/right, rotate left/right and clear, selected per cycle by `mode`. A self-timed burst engine loads a word and then shifts it right a programmed number of times, with `busy`/`done` handshake. It is used as the serialiser front end for the serial-link and LFSR blocks that follow.

---
 rtl/univ_shift_reg_pkg.sv | 26 ++
 rtl/univ_shift_reg_if.sv | 34 +++
 rtl/univ_shift_reg_core.sv | 37 +++
 rtl/univ_shift_reg.sv | 96 +++++++++
 tb/tb_univ_shift_reg.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg
//   Shared types for the universal shift register: the 3-bit operation codes
//   applied while idle, and the burst-engine state encoding.
// ----------------------------------------------------------------------------
package usr_pkg;

   localparam int USR_MODE_W = 3;

   typedef enum logic [USR_MODE_W-1:0] {
      MODE_HOLD  = 3'd0,
      MODE_SHR   = 3'd1,
      MODE_SHL   = 3'd2,
      MODE_LOAD  = 3'd3,
      MODE_ROR   = 3'd4,
      MODE_ROL   = 3'd5,
      MODE_CLEAR = 3'd6,
      MODE_RSVD  = 3'd7   // reserved, behaves as HOLD
   } usr_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } usr_state_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// ----------------------------------------------------------------------------
// univ_shift_reg_if
//   Control/data bundle of the universal shift register.
//   master : drives mode, din, ser_in_msb, ser_in_lsb, start, shift_count;
//            observes dout, sout_msb, sout_lsb, busy, done.
//   slave  : the register itself (opposite directions).
// ----------------------------------------------------------------------------
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2:0]       mode;
   logic [WIDTH-1:0] din;
   logic             ser_in_msb;
   logic             ser_in_lsb;
   logic             start;
   logic [CW-1:0]    shift_count;
   logic [WIDTH-1:0] dout;
   logic             sout_msb;
   logic             sout_lsb;
   logic             busy;
   logic             done;

   modport master (
      output mode, din, ser_in_msb, ser_in_lsb, start, shift_count,
      input  dout, sout_msb, sout_lsb, busy, done
   );

   modport slave (
      input  mode, din, ser_in_msb, ser_in_lsb, start, shift_count,
      output dout, sout_msb, sout_lsb, busy, done
   );
endinterface

// File: rtl/univ_shift_reg_core.sv
// ----------------------------------------------------------------------------
// usr_shift_core
//   Purely combinational next-value function of the shift register.
//   i_op         : operation to apply
//   i_dout       : current register contents
//   i_din        : parallel load data
//   i_ser_in_msb : bit entering at the MSB on a logical right shift
//   i_ser_in_lsb : bit entering at the LSB on a logical left shift
//   o_next       : value the register takes on the next edge
// ----------------------------------------------------------------------------
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  usr_mode_e        i_op,
   input  logic [WIDTH-1:0] i_dout,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_ser_in_msb,
   input  logic             i_ser_in_lsb,
   output logic [WIDTH-1:0] o_next
);

   always_comb begin
      o_next = i_dout;
      case (i_op)
         MODE_SHR:   o_next = {i_ser_in_msb, i_dout[WIDTH-1:1]};
         MODE_SHL:   o_next = {i_dout[WIDTH-2:0], i_ser_in_lsb};
         MODE_LOAD:  o_next = i_din;
         MODE_ROR:   o_next = {i_dout[0], i_dout[WIDTH-1:1]};
         MODE_ROL:   o_next = {i_dout[WIDTH-2:0], i_dout[WIDTH-1]};
         MODE_CLEAR: o_next = '0;
         default:    o_next = i_dout;   // HOLD and reserved code
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register with a self-timed burst engine.
//   While idle, bus.mode selects hold / shift / rotate / load / clear each
//   cycle. bus.start loads bus.din and then shifts right min(shift_count,
//   WIDTH) times, reporting progress on bus.busy and completion on a
//   one-cycle bus.done pulse.
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of univ_shift_reg_if (controls in, register state out)
// ----------------------------------------------------------------------------
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   univ_shift_reg_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   usr_state_e       r_state;
   logic [WIDTH-1:0] r_dout;
   logic [CW-1:0]    r_count;
   logic             r_done;

   usr_mode_e        w_op;
   logic [WIDTH-1:0] w_next;
   logic [CW-1:0]    w_sat_count;

   // Requested burst length, clamped so a burst never shifts more than WIDTH.
   assign w_sat_count = (bus.shift_count > CW'(WIDTH)) ? CW'(WIDTH) : bus.shift_count;

   // A burst start is expressed as a LOAD so every register update flows
   // through the one shared next-value function.
   always_comb begin
      w_op = usr_mode_e'(bus.mode);
      if (r_state == ST_RUN) begin
         w_op = MODE_SHR;
      end else if (bus.start) begin
         w_op = MODE_LOAD;
      end
   end

   usr_shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_op         (w_op),
      .i_dout       (r_dout),
      .i_din        (bus.din),
      .i_ser_in_msb (bus.ser_in_msb),
      .i_ser_in_lsb (bus.ser_in_lsb),
      .o_next       (w_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_dout  <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_dout <= w_next;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_count <= w_sat_count;
                  if (w_sat_count != '0) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_count <= r_count - CW'(1);
               if (r_count == CW'(1)) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.dout     = r_dout;
   assign bus.sout_msb = r_dout[WIDTH-1];
   assign bus.sout_lsb = r_dout[0];
   assign bus.busy     = (r_state == ST_RUN);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Randomised and directed stimulus for univ_shift_reg (WIDTH=8) with a
//   scoreboard: the driver pushes the expected post-edge outputs of a
//   behavioural model into a queue, an independent monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_univ_shift_reg;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] dout;
      logic         busy;
      logic         done;
   } exp_t;

   logic clock;
   logic reset;

   univ_shift_reg_if #(.WIDTH(W)) bus ();

   univ_shift_reg #(
      .WIDTH (W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   stim_done = 1'b0;

   // Behavioural model: value register plus "shifts still owed".
   int m_val  = 0;
   int m_left = 0;
   bit m_done = 1'b0;

   function automatic int shr(int v, bit msb);
      return (v >> 1) | (int'(msb) * 128);
   endfunction

   task automatic model_step(int mode, int din, bit smsb, bit slsb,
                             bit start, int cnt, bit rst);
      bit nd = 1'b0;
      if (rst) begin
         m_val = 0; m_left = 0; m_done = 1'b0;
         return;
      end
      if (m_left > 0) begin
         m_val  = shr(m_val, smsb);
         m_left = m_left - 1;
         if (m_left == 0) nd = 1'b1;
      end else if (start) begin
         m_val  = din;
         m_left = (cnt > W) ? W : cnt;
         if (m_left == 0) nd = 1'b1;
      end else begin
         case (mode)
            1: m_val = shr(m_val, smsb);
            2: m_val = ((m_val * 2) % 256) + int'(slsb);
            3: m_val = din;
            4: m_val = (m_val / 2) + (m_val % 2) * 128;
            5: m_val = ((m_val * 2) % 256) + (m_val / 128);
            6: m_val = 0;
            default: ;
         endcase
      end
      m_done = nd;
   endtask

   // One clock cycle of stimulus, applied at the falling edge.
   task automatic cyc(int mode, int din, bit smsb, bit slsb,
                      bit start, int cnt, bit rst);
      exp_t e;
      @(negedge clock);
      reset           = rst;
      bus.mode        = 3'(mode);
      bus.din         = W'(din);
      bus.ser_in_msb  = smsb;
      bus.ser_in_lsb  = slsb;
      bus.start       = start;
      bus.shift_count = 4'(cnt);
      model_step(mode, din, smsb, slsb, start, cnt, rst);
      e.dout = W'(m_val);
      e.busy = (m_left > 0);
      e.done = m_done;
      exp_q.push_back(e);
   endtask

   task automatic check(string name, int act, int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   // Monitor: every edge the DUT presents a new register state.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dout",     int'(bus.dout),     int'(e.dout));
            check("sout_msb", int'(bus.sout_msb), int'(e.dout[W-1]));
            check("sout_lsb", int'(bus.sout_lsb), int'(e.dout[0]));
            check("busy",     int'(bus.busy),     int'(e.busy));
            check("done",     int'(bus.done),     int'(e.done));
         end
      end
   end

   initial begin : watchdog
      #200000;
      if (!stim_done) begin
         $display("FAIL watchdog: stimulus not complete, expected completion");
         $display("%0d/%0d checks passed", n_pass, n_checks + 1);
         $fatal(1);
      end
   end

   initial begin : driver
      reset = 1'b1;
      bus.mode = '0; bus.din = '0; bus.ser_in_msb = 1'b0; bus.ser_in_lsb = 1'b0;
      bus.start = 1'b0; bus.shift_count = '0;

      // Reset, then idle under HOLD.
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      repeat (3) cyc(0, 8'h5A, 1, 1, 0, 0, 0);

      // Mode operations on 0xA5.
      cyc(3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);        // SHR -> D2
      cyc(3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(2, 0, 0, 0, 0, 0, 0);        // SHL -> 4A
      cyc(3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(5, 0, 0, 0, 0, 0, 0);        // ROL -> 4B
      cyc(3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(4, 0, 0, 0, 0, 0, 0);        // ROR -> D2
      cyc(6, 0, 0, 0, 0, 0, 0);        // CLEAR
      cyc(7, 8'hFF, 1, 1, 0, 0, 0);    // reserved holds

      // Burst of 4 on 0xF0, then hold.
      cyc(0, 8'hF0, 0, 0, 1, 4, 0);
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

      // Zero-length burst.
      cyc(0, 8'h3C, 0, 0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

      // Saturating burst: 15 -> 8 shifts filling with ones.
      cyc(0, 8'h00, 1, 0, 1, 15, 0);
      repeat (9) cyc(0, 0, 1, 0, 0, 0, 0);

      // Start/mode while busy are ignored.
      cyc(0, 8'h81, 0, 0, 1, 3, 0);
      cyc(3, 8'h77, 1, 0, 1, 8, 0);
      cyc(3, 8'h66, 0, 1, 1, 2, 0);
      cyc(3, 8'h55, 1, 0, 0, 0, 0);
      // New start accepted in the done cycle.
      cyc(0, 8'hC3, 0, 0, 1, 2, 0);
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);

      // Reset mid-burst: no done pulse afterwards.
      cyc(0, 8'hAA, 1, 0, 1, 5, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 49) == 0));
      end

      @(posedge clock);
      #2;
      check("queue_drained", exp_q.size(), 0);
      stim_done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
